mem_stage: RTL



---
 rtl/mem_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: registers execute-stage buses, tracks the data-SRAM read response,
// aligns/extends load data and drives write-back, forwarding and HI/LO buses.
module mem_stage #(
  parameter int unsigned STALL_W  = 6,
  parameter int unsigned MEM_IN_W = 76
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic [MEM_IN_W-1:0] ex_to_mem_bus,
  input  logic [4:0]          ex_load_bus,
  input  logic [3:0]          ex_data_ram_sel,
  input  logic [65:0]         ex_hi_lo_bus,
  input  logic [31:0]         data_sram_rdata,
  input  logic                data_sram_data_ok,
  output logic [69:0]         mem_to_wb_bus,
  output logic [37:0]         mem_to_rf_bus,
  output logic [65:0]         mem_hi_lo_bus,
  output logic                mem_load_pending,
  output logic                stallreq_for_mem
);

  logic [MEM_IN_W-1:0] ex_bus_r;
  logic [4:0]          load_bus_r;
  logic [3:0]          sel_r;
  logic [65:0]         hi_lo_r;
  logic [31:0]         rdata_buf;
  logic                got_data;

  logic capture, bubble;
  assign capture = ~stall[3];
  assign bubble  = stall[3] & ~stall[4];

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_bus_r   <= '0;
      load_bus_r <= '0;
      sel_r      <= '0;
      hi_lo_r    <= '0;
    end else if (capture) begin
      ex_bus_r   <= ex_to_mem_bus;
      load_bus_r <= ex_load_bus;
      sel_r      <= ex_data_ram_sel;
      hi_lo_r    <= ex_hi_lo_bus;
    end
  end

  logic [31:0] pc_r, ex_result_r;
  logic        ram_en_r, sel_rf_res_r, rf_we_r;
  logic [3:0]  ram_wen_r;
  logic [4:0]  rf_waddr_r;

  assign pc_r         = ex_bus_r[75:44];
  assign ram_en_r     = ex_bus_r[43];
  assign ram_wen_r    = ex_bus_r[42:39];
  assign sel_rf_res_r = ex_bus_r[38];
  assign rf_we_r      = ex_bus_r[37];
  assign rf_waddr_r   = ex_bus_r[36:32];
  assign ex_result_r  = ex_bus_r[31:0];

  logic is_load, ready;
  assign is_load = ram_en_r & (ram_wen_r == 4'b0000) & (|load_bus_r);

  // Hold the response so a downstream stall does not lose it once the SRAM moves on.
  always_ff @(posedge clk) begin
    if (rst || capture || bubble) begin
      rdata_buf <= '0;
      got_data  <= 1'b0;
    end else if (is_load && data_sram_data_ok && !got_data) begin
      rdata_buf <= data_sram_rdata;
      got_data  <= 1'b1;
    end
  end

  logic [31:0] raw;
  assign raw   = got_data ? rdata_buf : data_sram_rdata;
  assign ready = ~is_load | got_data | data_sram_data_ok;

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        byte_ok, half_ok;
  logic [31:0] load_data;

  always_comb begin
    byte_v  = 8'h00;
    byte_ok = 1'b1;
    unique case (sel_r)
      4'b0001: byte_v = raw[7:0];
      4'b0010: byte_v = raw[15:8];
      4'b0100: byte_v = raw[23:16];
      4'b1000: byte_v = raw[31:24];
      default: byte_ok = 1'b0;
    endcase
    half_v  = 16'h0000;
    half_ok = 1'b1;
    unique case (sel_r)
      4'b0011: half_v = raw[15:0];
      4'b1100: half_v = raw[31:16];
      default: half_ok = 1'b0;
    endcase
    load_data = '0;
    case (load_bus_r)
      5'b10000: if (byte_ok) load_data = {{24{byte_v[7]}}, byte_v};
      5'b01000: if (byte_ok) load_data = {24'h0, byte_v};
      5'b00100: if (half_ok) load_data = {{16{half_v[15]}}, half_v};
      5'b00010: if (half_ok) load_data = {16'h0, half_v};
      5'b00001: load_data = raw;
      default:  load_data = '0;
    endcase
  end

  logic [31:0] rf_wdata;
  logic        wb_we;
  assign rf_wdata = sel_rf_res_r ? load_data : ex_result_r;
  assign wb_we    = rf_we_r & ready;

  // Outputs are forced low while rst is high so nothing stale leaks during reset.
  assign mem_to_wb_bus    = rst ? '0 : {pc_r, wb_we, rf_waddr_r, rf_wdata};
  assign mem_to_rf_bus    = rst ? '0 : {wb_we, rf_waddr_r, rf_wdata};
  assign mem_hi_lo_bus    = rst ? '0 : hi_lo_r;
  assign mem_load_pending = ~rst & is_load & ~ready;
  assign stallreq_for_mem = ~rst & is_load & ~ready;

  logic unused_stall;
  assign unused_stall = ^{stall[STALL_W-1:5], stall[2:0]};

endmodule
